// File: rtl/register_manager_param.sv
// register_manager_param: merges writeback channels through a pending-write FIFO into int/float banks,
// serving forwarded operand reads with one cycle of latency.
module register_manager_param #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 5,
    parameter int NUM_WRITE_PORTS = 4,
    parameter int NUM_READ_PORTS  = 2,
    parameter int QUEUE_DEPTH     = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_WRITE_PORTS-1:0]            write_enable,
    input  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] write_addr,
    input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] write_data,
    input  logic [NUM_WRITE_PORTS-1:0]            write_float,
    output logic                                  stall,
    output logic                                  overflow,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  read_addr,
    input  logic [NUM_READ_PORTS-1:0]             read_float,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  read_data,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]      pending_count
);
    localparam int DW   = DATA_WIDTH;
    localparam int AW   = ADDR_WIDTH;
    localparam int NW   = NUM_WRITE_PORTS;
    localparam int NR   = NUM_READ_PORTS;
    localparam int QD   = QUEUE_DEPTH;
    localparam int CW   = $clog2(QD + 1);
    localparam int PW   = QD > 1 ? $clog2(QD) : 1;
    localparam int NREG = 2 ** AW;

    // Operands are always below 2*QD, so one conditional subtraction wraps them.
    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v >= QD ? v - QD : v);
    endfunction

    logic [DW-1:0] bank_int_q [NREG];
    logic [DW-1:0] bank_flt_q [NREG];
    logic [AW-1:0] fifo_addr_q [QD];
    logic [DW-1:0] fifo_data_q [QD];
    logic [QD-1:0] fifo_flt_q;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d, n_acc;
    logic          ovf_q;
    logic [NW-1:0] acc;
    logic [PW-1:0] slot [NW];
    logic [PW-1:0] fidx [QD];
    logic [DW-1:0] rd_q [NR];
    logic [DW-1:0] rd_d [NR];
    logic [AW-1:0] ra_q [NR];
    logic [NR-1:0] rf_q;

    assign stall         = int'(count_q) + NW > QD;
    assign overflow      = ovf_q;
    assign pending_count = count_q;

    always_comb begin
        n_acc = '0;
        for (int i = 0; i < NW; i++) begin
            acc[i]  = !stall && write_enable[i] && (write_float[i] || write_addr[i*AW +: AW] != '0);
            slot[i] = wrap(int'(tail_q) + int'(n_acc));
            n_acc   = n_acc + CW'(acc[i]);
        end
        for (int k = 0; k < QD; k++) fidx[k] = wrap(int'(head_q) + k);
        head_d  = count_q != '0 ? wrap(int'(head_q) + 1) : head_q;
        tail_d  = wrap(int'(tail_q) + int'(n_acc));
        count_d = count_q - CW'(count_q != '0) + n_acc;
    end

    // Priority grows along each loop: bank, then FIFO oldest->youngest, then this cycle's writes.
    always_comb begin
        read_data = '0;
        for (int r = 0; r < NR; r++) begin
            rd_d[r] = read_float[r] ? bank_flt_q[read_addr[r*AW +: AW]] : bank_int_q[read_addr[r*AW +: AW]];
            for (int k = 0; k < QD; k++)
                if (k < int'(count_q) && fifo_addr_q[fidx[k]] == read_addr[r*AW +: AW]
                    && fifo_flt_q[fidx[k]] == read_float[r])
                    rd_d[r] = fifo_data_q[fidx[k]];
            for (int i = 0; i < NW; i++)
                if (acc[i] && write_addr[i*AW +: AW] == read_addr[r*AW +: AW] && write_float[i] == read_float[r])
                    rd_d[r] = write_data[i*DW +: DW];
            if (!read_float[r] && read_addr[r*AW +: AW] == '0) rd_d[r] = '0;
            read_data[r*DW +: DW] = rd_q[r];
            for (int i = 0; i < NW; i++)
                if (acc[i] && write_addr[i*AW +: AW] == ra_q[r] && write_float[i] == rf_q[r])
                    read_data[r*DW +: DW] = write_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            rf_q    <= '0;
            for (int r = 0; r < NR; r++) begin
                rd_q[r] <= '0;
                ra_q[r] <= '0;
            end
            for (int a = 0; a < NREG; a++) begin
                bank_int_q[a] <= '0;
                bank_flt_q[a] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_q | (stall & |write_enable);
            rf_q    <= read_float;
            for (int r = 0; r < NR; r++) begin
                rd_q[r] <= rd_d[r];
                ra_q[r] <= read_addr[r*AW +: AW];
            end
            if (count_q != '0) begin
                if (fifo_flt_q[head_q]) bank_flt_q[fifo_addr_q[head_q]] <= fifo_data_q[head_q];
                else bank_int_q[fifo_addr_q[head_q]] <= fifo_data_q[head_q];
            end
        end
    end

    // Entry storage is only meaningful below count_q, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NW; i++) begin
            if (acc[i]) begin
                fifo_addr_q[slot[i]] <= write_addr[i*AW +: AW];
                fifo_data_q[slot[i]] <= write_data[i*DW +: DW];
                fifo_flt_q[slot[i]]  <= write_float[i];
            end
        end
    end
endmodule

// File: tb/tb_register_manager_param.sv
// tb_register_manager_param: directed bench with a read scoreboard for register_manager_param.
module tb_register_manager_param;
    logic        clk = 0;
    logic        reset;
    logic [3:0]  write_enable;
    logic [19:0] write_addr;
    logic [127:0] write_data;
    logic [3:0]  write_float;
    logic        stall, overflow;
    logic [9:0]  read_addr;
    logic [1:0]  read_float;
    logic [63:0] read_data;
    logic [3:0]  pending_count;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];
    int passed = 0, failed = 0, total = 0;

    register_manager_param dut (
        .clk(clk), .reset(reset), .write_enable(write_enable), .write_addr(write_addr),
        .write_data(write_data), .write_float(write_float), .stall(stall), .overflow(overflow),
        .read_addr(read_addr), .read_float(read_float), .read_data(read_data),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d, input logic f);
        write_enable[p]        = 1'b1;
        write_addr[p*5 +: 5]   = 5'(a);
        write_data[p*32 +: 32] = d;
        write_float[p]         = f;
    endtask

    task automatic rd(input int p, input int a, input logic f, input logic [31:0] exp, input string tag);
        read_addr[p*5 +: 5] = 5'(a);
        read_float[p]       = f;
        sb.push_back('{tag, p, exp});
    endtask

    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        write_enable = '0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, read_data[e.port*32 +: 32], e.exp);
        end
    endtask

    initial begin
        reset = 1; write_enable = '0; write_addr = '0; write_data = '0; write_float = '0;
        read_addr = '0; read_float = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", read_data[31:0], 0);
        check("rst_ovf", 32'(overflow), 0);
        reset = 0;
        // reset values visible through reads
        rd(0, 3, 0, 0, "rd_int_r3");
        rd(1, 3, 1, 0, "rd_flt_r3");
        tick();
        check("rst_count", 32'(pending_count), 0);
        check("rst_stall", 32'(stall), 0);
        // same-cycle write forwarding, then after drain
        wr(1, 5, 32'hDEADBEEF, 0);
        rd(0, 5, 0, 32'hDEADBEEF, "fwd_same_cycle");
        tick();
        check("count_after_wr", 32'(pending_count), 1);
        rd(0, 5, 0, 32'hDEADBEEF, "r5_from_fifo");
        tick();
        check("count_drained", 32'(pending_count), 0);
        rd(0, 5, 0, 32'hDEADBEEF, "r5_from_bank");
        tick();
        // ordering: youngest port wins, float bank separate
        wr(0, 7, 1, 0); wr(2, 7, 2, 0); wr(3, 7, 3, 1);
        tick();
        check("count_three", 32'(pending_count), 3);
        rd(0, 7, 0, 2, "r7_int_fifo");
        rd(1, 7, 1, 3, "r7_flt_fifo");
        tick();
        tick(); tick();
        check("count_r7_drained", 32'(pending_count), 0);
        rd(0, 7, 0, 2, "r7_int_bank");
        rd(1, 7, 1, 3, "r7_flt_bank");
        tick();
        // a write arriving in the output cycle is forwarded to the read result
        rd(0, 9, 0, 0, "r9_before");
        tick();
        wr(2, 9, 32'hCAFE, 0);
        #1;
        check("fwd_out_cycle", read_data[31:0], 32'hCAFE);
        tick();
        tick();
        rd(1, 9, 0, 32'hCAFE, "r9_bank");
        tick();
        // fill to stall, overflow, drain
        for (int p = 0; p < 4; p++) wr(p, 10 + p, 32'h100 + 10 + p, 0);
        tick();
        check("fill_count4", 32'(pending_count), 4);
        check("fill_stall0", 32'(stall), 0);
        for (int p = 0; p < 4; p++) wr(p, 14 + p, 32'h100 + 14 + p, 0);
        tick();
        check("fill_count7", 32'(pending_count), 7);
        check("fill_stall1", 32'(stall), 1);
        check("ovf_not_yet", 32'(overflow), 0);
        for (int p = 0; p < 4; p++) wr(p, 18 + p, 32'h100 + 18 + p, 0);
        tick();
        check("ovf_set", 32'(overflow), 1);
        check("ignored_count6", 32'(pending_count), 6);
        tick();
        check("count5_stall", 32'(stall), 1);
        tick();
        check("count4_stall", 32'(stall), 0);
        for (int n = 0; n < 20 && pending_count != 0; n++) tick();
        check("fill_drained", 32'(pending_count), 0);
        check("ovf_sticky", 32'(overflow), 1);
        for (int a = 10; a < 22; a += 2) begin
            rd(0, a, 0, a <= 17 ? 32'h100 + a : 0, "fill_bank_even");
            rd(1, a + 1, 0, a + 1 <= 17 ? 32'h100 + a + 1 : 0, "fill_bank_odd");
            tick();
        end
        // int r0 discarded, float r0 ordinary
        wr(0, 0, 32'hFFFF, 0);
        rd(0, 0, 0, 0, "int_r0_fwd");
        tick();
        check("int_r0_no_entry", 32'(pending_count), 0);
        wr(0, 0, 32'hFFFF, 1);
        tick();
        check("flt_r0_entry", 32'(pending_count), 1);
        tick();
        rd(0, 0, 1, 32'hFFFF, "flt_r0_bank");
        rd(1, 0, 0, 0, "int_r0_bank");
        tick();
        // async reset with pending writes
        for (int p = 0; p < 4; p++) wr(p, 22 + p, 32'h200 + 22 + p, 0);
        tick();
        for (int p = 0; p < 4; p++) wr(p, 26 + p, 32'h200 + 26 + p, 0);
        tick();
        tick();
        check("pre_reset_count6", 32'(pending_count), 6);
        reset = 1;
        #1;
        check("async_rst_count", 32'(pending_count), 0);
        check("async_rst_ovf", 32'(overflow), 0);
        @(posedge clk);
        #1;
        reset = 0;
        for (int a = 24; a < 30; a += 2) begin
            rd(0, a, 0, 0, "dropped_even");
            rd(1, a + 1, 0, 0, "dropped_odd");
            tick();
        end
        rd(0, 10, 0, 0, "bank_cleared");
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/register_manager_param.md
Name: register_manager_param

Overview:
- Parametrised next-generation register manager. Merges NUM_WRITE_PORTS writeback channels into a pending-write FIFO. The FIFO drains one entry per cycle into separate int and float register banks.
- Serves NUM_READ_PORTS operand reads with 1-cycle latency and full forwarding: same-cycle writes first, then the FIFO, then the bank.
- Sits between the decode stage (reads) and the misc/alu/mem/fpu writeback units. Adds backpressure and int r0 = 0 semantics, which the previous generation did not have.

Parameters:
- DATA_WIDTH, 32, register width.
- ADDR_WIDTH, 5, register index width; each bank holds 2**ADDR_WIDTH entries.
- NUM_WRITE_PORTS, 4, writeback channels; port 0 is oldest, the highest index is youngest.
- NUM_READ_PORTS, 2, operand read ports.
- QUEUE_DEPTH, 8, pending-write FIFO entries; must be >= NUM_WRITE_PORTS.

Ports:
- clk, input, 1, single clock; all state on posedge.
- reset, input, 1, asynchronous active-high reset.
- write_enable, input, NUM_WRITE_PORTS, per-port write request.
- write_addr, input, NUM_WRITE_PORTS*ADDR_WIDTH, flattened; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- write_data, input, NUM_WRITE_PORTS*DATA_WIDTH, flattened, same packing as write_addr.
- write_float, input, NUM_WRITE_PORTS, 1 = float bank, 0 = int bank.
- stall, output, 1, writes are not accepted this cycle.
- overflow, output, 1, sticky flag: a write was presented while stall was high.
- read_addr, input, NUM_READ_PORTS*ADDR_WIDTH, flattened; sampled on posedge.
- read_float, input, NUM_READ_PORTS, bank select; sampled together with read_addr.
- read_data, output, NUM_READ_PORTS*DATA_WIDTH, flattened; valid in the cycle after sampling.
- pending_count, output, clog2(QUEUE_DEPTH+1), current FIFO occupancy.

Behaviour:
- Reset (asynchronous):
  - Both banks cleared to 0; FIFO emptied; read registers set to 0.
  - Outputs: overflow=0, stall=0, pending_count=0, read_data=0.
  - Reset during operation drops all pending writes; nothing is committed to the banks.
- Stall:
  - stall = (pending_count + NUM_WRITE_PORTS > QUEUE_DEPTH); combinational from registered occupancy.
  - While stall=1, every write_enable is ignored.
  - Any write_enable bit set while stall=1 sets overflow, which holds until reset.
- Accept: a write is accepted when stall=0, its enable bit is 1, and it is not (write_float=0 and addr=0).
  - Int r0 writes are discarded silently and never set overflow.
- Enqueue: at posedge, accepted writes are appended to the FIFO in ascending port order.
  - A FIFO entry is {addr, data, float}.
- Drain: at each posedge with occupancy > 0 before enqueue, the oldest entry is written to its bank.
  - Drain and enqueue happen on the same edge.
  - Next count = count - drained + accepted.
- Wrap-around: the FIFO is a circular buffer; head and tail wrap modulo QUEUE_DEPTH.
- Ordering: multiple writes to the same {float, addr} are committed in FIFO order, so the youngest value wins in the bank.
- Read resolution at posedge, per read port; the first match in this order is captured in a read register:
  1. Highest-index accepted write this cycle with matching {float, addr}.
  2. Youngest matching FIFO entry, including the entry draining this cycle.
  3. The bank value.
- Read output in the following cycle:
  - read_data = the highest-index accepted write in that cycle with matching {sampled float, sampled addr}.
  - Otherwise read_data = the read register.
  - This gives a 1-cycle read latency with no hazard window.
- Int r0: a read of int address 0 always returns 0, regardless of writes. Float address 0 is an ordinary register.
- Conflicts: two read ports with the same address return identical data. A read and a write to the same register in the same cycle return the new data in the next cycle.

Test Plan:
- Reset, then read int r3 and float r3 -> both read_data = 0; pending_count=0, stall=0.
- Cycle 0: port1 writes int r5 = 0xDEADBEEF and read port0 samples int r5 -> cycle 1: read_data0 = 0xDEADBEEF; it is still read correctly after the entry drains (pending_count returns to 0).
- One cycle: port0 writes int r7=1, port2 writes int r7=2, port3 writes float r7=3 -> after drain, int r7 reads 2 and float r7 reads 3.
- All 4 ports write every cycle (QUEUE_DEPTH=8) -> pending_count goes 0→4→7 and stall rises at count 5+. Continuing writes set overflow=1; with enables low, the FIFO drains to 0, stall falls, and all accepted values are present in the banks.
- Write int r0 = 0xFFFF -> no FIFO entry; an int r0 read returns 0. The same write to float r0 -> a float r0 read returns 0xFFFF.
- Assert reset while pending_count=6 -> pending_count=0 and overflow=0 immediately; none of the pending values appear in the banks.
